wr_ingress_ctrl: RTL and testbench

WR_INGRESS_CTRL -- requirements
Module: wr_ingress_ctrl

---
 rtl/wr_ingress_pkg.sv | 13 +
 rtl/wr_ingress_ctrl_gray2bin.sv | 17 +
 rtl/wr_ingress_ctrl.sv | 129 ++++++++++++
 tb/tb_wr_ingress_ctrl.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/wr_ingress_pkg.sv
// Shared types for the write-side ingress controller.
// State encoding for the skid buffer and stall counter width.
package wr_ingress_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    HALF  = 2'd1,
    FULL  = 2'd2
  } state_e;

  localparam int STALL_CNT_W = 16;

endpackage

// File: rtl/wr_ingress_ctrl_gray2bin.sv
// Gray-code to binary converter, purely combinational.
// Each binary bit is the XOR of all Gray bits at or above it.
module gray2bin #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] gray,
  output logic [WIDTH-1:0] bin
);

  always_comb begin
    bin = '0;
    for (int i = 0; i < WIDTH; i++) begin
      bin[i] = ^(gray >> i);
    end
  end

endmodule

// File: rtl/wr_ingress_ctrl.sv
// Write-domain ingress: skid buffer feeding an async FIFO write port,
// plus occupancy estimate, almost-full flag and stall counter.
module wr_ingress_ctrl
  import wr_ingress_pkg::*;
#(
  parameter int DATA_WIDTH   = 8,
  parameter int PTR_WIDTH    = 3,
  parameter int AFULL_THRESH = 6
) (
  input  logic                   wrclk,
  input  logic                   wrst_n,
  input  logic                   in_valid,
  input  logic [DATA_WIDTH-1:0]  in_data,
  output logic                   in_ready,
  input  logic                   fifo_full,
  input  logic [PTR_WIDTH:0]     b_wptr,
  input  logic [PTR_WIDTH:0]     g_rptr_sync,
  output logic                   wr_en,
  output logic [DATA_WIDTH-1:0]  wr_data,
  output logic [PTR_WIDTH:0]     wr_level,
  output logic                   almost_full,
  output logic [STALL_CNT_W-1:0] stall_cnt
);

  localparam logic [PTR_WIDTH:0] AFULL_L =
    (PTR_WIDTH+1)'(AFULL_THRESH);

  state_e                  state_q, state_d;
  logic [DATA_WIDTH-1:0]   main_q, main_d;
  logic [DATA_WIDTH-1:0]   skid_q, skid_d;
  logic                    in_ready_q, in_ready_d;
  logic [PTR_WIDTH:0]      level_q, level_d;
  logic                    afull_q, afull_d;
  logic [STALL_CNT_W-1:0]  stall_q, stall_d;
  logic [PTR_WIDTH:0]      b_rptr;
  logic                    accept;
  logic                    drain;

  gray2bin #(
    .WIDTH (PTR_WIDTH+1)
  ) u_g2b (
    .gray (g_rptr_sync),
    .bin  (b_rptr)
  );

  assign accept = in_valid & in_ready_q;
  assign drain  = wr_en;

  always_ff @(posedge wrclk or negedge wrst_n) begin
    if (!wrst_n) begin
      state_q <= EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    unique case (state_q)
      EMPTY: begin
        if (accept) begin
          state_d = HALF;
          main_d  = in_data;
        end
      end
      HALF: begin
        unique case (1'b1)
          accept && !drain: begin
            state_d = FULL;
            skid_d  = in_data;
          end
          accept && drain: begin
            main_d = in_data;
          end
          !accept && drain: begin
            state_d = EMPTY;
          end
          default: ;
        endcase
      end
      FULL: begin
        if (drain) begin
          state_d = HALF;
          main_d  = skid_q;
        end
      end
      default: state_d = EMPTY;
    endcase
  end

  // fifo_full only blocks draining; in_ready follows buffer space alone
  always_comb begin
    wr_en      = (state_q != EMPTY) & ~fifo_full;
    in_ready_d = (state_d != FULL);
    level_d    = b_wptr - b_rptr;
    afull_d    = (level_d >= AFULL_L);
    stall_d    = stall_q;
    if ((state_q != EMPTY) && fifo_full && (stall_q != '1)) begin
      stall_d = stall_q + 1'b1;
    end
  end

  always_ff @(posedge wrclk or negedge wrst_n) begin
    if (!wrst_n) begin
      main_q     <= '0;
      skid_q     <= '0;
      in_ready_q <= 1'b0;
      level_q    <= '0;
      afull_q    <= 1'b0;
      stall_q    <= '0;
    end else begin
      main_q     <= main_d;
      skid_q     <= skid_d;
      in_ready_q <= in_ready_d;
      level_q    <= level_d;
      afull_q    <= afull_d;
      stall_q    <= stall_d;
    end
  end

  assign in_ready    = in_ready_q;
  assign wr_data     = main_q;
  assign wr_level    = level_q;
  assign almost_full = afull_q;
  assign stall_cnt   = stall_q;

endmodule

// File: tb/tb_wr_ingress_ctrl.sv
// Directed bench for wr_ingress_ctrl: handshake, skid, level,
// stall saturation and reset behaviour.
module tb_wr_ingress_ctrl;

  logic        wrclk;
  logic        wrst_n;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_ready;
  logic        fifo_full;
  logic [3:0]  b_wptr;
  logic [3:0]  g_rptr_sync;
  logic        wr_en;
  logic [7:0]  wr_data;
  logic [3:0]  wr_level;
  logic        almost_full;
  logic [15:0] stall_cnt;

  int n_chk;
  int n_fail;

  wr_ingress_ctrl #(
    .DATA_WIDTH   (8),
    .PTR_WIDTH    (3),
    .AFULL_THRESH (6)
  ) dut (
    .wrclk       (wrclk),
    .wrst_n      (wrst_n),
    .in_valid    (in_valid),
    .in_data     (in_data),
    .in_ready    (in_ready),
    .fifo_full   (fifo_full),
    .b_wptr      (b_wptr),
    .g_rptr_sync (g_rptr_sync),
    .wr_en       (wr_en),
    .wr_data     (wr_data),
    .wr_level    (wr_level),
    .almost_full (almost_full),
    .stall_cnt   (stall_cnt)
  );

  initial wrclk = 1'b0;
  always #5 wrclk = ~wrclk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge wrclk);
    #1;
  endtask

  initial begin
    n_chk       = 0;
    n_fail      = 0;
    wrst_n      = 1'b0;
    in_valid    = 1'b0;
    in_data     = 8'h00;
    fifo_full   = 1'b0;
    b_wptr      = 4'd0;
    g_rptr_sync = 4'd0;
    #3;
    chk("rst_in_ready", 32'(in_ready), 32'h0);
    chk("rst_wr_en", 32'(wr_en), 32'h0);
    chk("rst_wr_data", 32'(wr_data), 32'h0);
    chk("rst_level", 32'(wr_level), 32'h0);
    chk("rst_afull", 32'(almost_full), 32'h0);
    chk("rst_stall", 32'(stall_cnt), 32'h0);
    step();
    step();
    wrst_n = 1'b1;
    step();
    chk("ready_after_rst", 32'(in_ready), 32'h1);
    chk("idle_wr_en", 32'(wr_en), 32'h0);

    // streaming 0x11, 0x22, 0x33
    in_valid = 1'b1;
    in_data  = 8'h11;
    step();
    chk("s1_wr_en", 32'(wr_en), 32'h1);
    chk("s1_wr_data", 32'(wr_data), 32'h11);
    in_data = 8'h22;
    step();
    chk("s2_wr_en", 32'(wr_en), 32'h1);
    chk("s2_wr_data", 32'(wr_data), 32'h22);
    chk("s2_ready", 32'(in_ready), 32'h1);
    in_data = 8'h33;
    step();
    chk("s3_wr_en", 32'(wr_en), 32'h1);
    chk("s3_wr_data", 32'(wr_data), 32'h33);
    in_valid = 1'b0;
    step();
    chk("s_empty_wr_en", 32'(wr_en), 32'h0);
    chk("s_empty_ready", 32'(in_ready), 32'h1);

    // skid fill while FIFO full
    in_valid  = 1'b1;
    in_data   = 8'hA1;
    fifo_full = 1'b1;
    step();
    chk("k1_wr_en", 32'(wr_en), 32'h0);
    chk("k1_wr_data", 32'(wr_data), 32'hA1);
    chk("k1_ready", 32'(in_ready), 32'h1);
    in_data = 8'hA2;
    step();
    chk("k2_ready", 32'(in_ready), 32'h0);
    chk("k2_wr_en", 32'(wr_en), 32'h0);
    chk("k2_wr_data", 32'(wr_data), 32'hA1);
    chk("k2_stall", 32'(stall_cnt), 32'h1);
    in_valid  = 1'b0;
    in_data   = 8'hEE;
    fifo_full = 1'b0;
    #1;
    chk("k3_wr_en", 32'(wr_en), 32'h1);
    chk("k3_wr_data", 32'(wr_data), 32'hA1);
    step();
    chk("k4_wr_en", 32'(wr_en), 32'h1);
    chk("k4_wr_data", 32'(wr_data), 32'hA2);
    chk("k4_ready", 32'(in_ready), 32'h1);
    step();
    chk("k5_wr_en", 32'(wr_en), 32'h0);
    chk("k5_stall", 32'(stall_cnt), 32'h1);

    // level and almost_full
    b_wptr      = 4'b0010;
    g_rptr_sync = 4'b1001;
    step();
    chk("lv_wrap", 32'(wr_level), 32'h4);
    chk("af_wrap", 32'(almost_full), 32'h0);
    b_wptr      = 4'b1000;
    g_rptr_sync = 4'b0000;
    step();
    chk("lv_full", 32'(wr_level), 32'h8);
    chk("af_full", 32'(almost_full), 32'h1);
    b_wptr = 4'b0110;
    step();
    chk("lv_thr", 32'(wr_level), 32'h6);
    chk("af_thr", 32'(almost_full), 32'h1);
    b_wptr = 4'b0101;
    step();
    chk("lv_below", 32'(wr_level), 32'h5);
    chk("af_below", 32'(almost_full), 32'h0);
    b_wptr = 4'b0000;

    // stall saturation
    in_valid  = 1'b1;
    in_data   = 8'h5C;
    fifo_full = 1'b1;
    step();
    in_valid = 1'b0;
    for (int i = 0; i < 70000; i++) begin
      step();
    end
    chk("stall_sat", 32'(stall_cnt), 32'hFFFF);
    chk("stall_hold_data", 32'(wr_data), 32'h5C);
    step();
    chk("stall_sat2", 32'(stall_cnt), 32'hFFFF);

    // reset while FULL
    in_valid = 1'b1;
    in_data  = 8'h6D;
    b_wptr   = 4'b0011;
    step();
    chk("f_ready", 32'(in_ready), 32'h0);
    chk("f_level", 32'(wr_level), 32'h3);
    in_valid  = 1'b0;
    fifo_full = 1'b0;
    #1;
    chk("f_wr_en", 32'(wr_en), 32'h1);
    wrst_n = 1'b0;
    #1;
    chk("r_ready", 32'(in_ready), 32'h0);
    chk("r_wr_en", 32'(wr_en), 32'h0);
    chk("r_level", 32'(wr_level), 32'h0);
    chk("r_stall", 32'(stall_cnt), 32'h0);
    chk("r_wr_data", 32'(wr_data), 32'h0);
    step();
    wrst_n = 1'b1;
    step();
    chk("r2_ready", 32'(in_ready), 32'h1);
    chk("r2_wr_en", 32'(wr_en), 32'h0);
    chk("r2_level", 32'(wr_level), 32'h3);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
